mult_result_collector: RTL and testbench

Downstream capture stage for the lane-parallel floating-point multiply array. The array has a fixed pipeline latency and no backpressure, so this block tracks which cycles carry valid results, captures the lane vector into a first-word-fall-through FIFO, and presents it on a ready/valid output. It issues credits upstream so the array is never driven with more operands than the FIFO can absorb.

---
 rtl/mult_result_collector.sv | 120 ++++++++++++
 tb/tb_mult_result_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_collector.sv
// Capture stage for the multiply array: credit-based issue control, valid delay line
// and FWFT result FIFO with ready/valid output. Optional last-flag path: COLLECT_LAST_EN.
module mult_result_collector #(
  parameter int unsigned dataWidth   = 32,
  parameter int unsigned pactivation = 16,
  parameter int unsigned LATENCY     = 8,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [dataWidth*pactivation-1:0]   mult_result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [dataWidth*pactivation-1:0]   out_data,
  output logic                               out_last,
  output logic [$clog2(DEPTH):0]             credits,
  output logic                               overflow
);

  localparam int unsigned DW = dataWidth * pactivation;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]      credits_q, credits_d;
  logic [CW-1:0]      occ_q, occ_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic               overflow_q, overflow_d;
  logic [DW-1:0]      mem_q [DEPTH];

  logic issue_c, pop_c, cap_c, full_c, wr_c;

  assign in_ready  = (credits_q != '0);
  assign issue_c   = in_valid & in_ready;
  assign out_valid = (occ_q != '0);
  assign pop_c     = out_valid & out_ready;
  assign cap_c     = vld_q[LATENCY-1];
  assign full_c    = (occ_q == CW'(DEPTH));
  // A pop on the same edge frees the slot, so a write into a full FIFO is legal then
  assign wr_c      = cap_c & (~full_c | pop_c);

  assign credits  = credits_q;
  assign overflow = overflow_q;
  assign out_data = mem_q[rptr_q];

  always_comb begin
    credits_d  = credits_q;
    occ_d      = occ_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    vld_d      = LATENCY'({vld_q, issue_c});

    if (issue_c && !pop_c)      credits_d = credits_q - CW'(1);
    else if (pop_c && !issue_c) credits_d = credits_q + CW'(1);

    if (wr_c && !pop_c)      occ_d = occ_q + CW'(1);
    else if (pop_c && !wr_c) occ_d = occ_q - CW'(1);

    if (wr_c)  wptr_d = wptr_q + PW'(1);
    if (pop_c) rptr_d = rptr_q + PW'(1);

    if (cap_c && full_c && !pop_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q  <= CW'(DEPTH);
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      vld_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
    end
  end

  // Data storage needs no reset; occupancy gates visibility of every entry
  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wptr_q] <= mult_result;
  end

`ifdef COLLECT_LAST_EN
  logic [LATENCY-1:0] lst_q, lst_d;
  logic [DEPTH-1:0]   lmem_q, lmem_d;

  always_comb begin
    lst_d  = LATENCY'({lst_q, in_last & issue_c});
    lmem_d = lmem_q;
    if (wr_c) lmem_d[wptr_q] = lst_q[LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lst_q  <= '0;
      lmem_q <= '0;
    end else begin
      lst_q  <= lst_d;
      lmem_q <= lmem_d;
    end
  end

  assign out_last = out_valid & lmem_q[rptr_q];
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign out_last       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_result_collector.sv
// Directed + random bench for mult_result_collector, checked against a queue-based
// model of in-flight issues and FIFO contents.
module tb_mult_result_collector;

  localparam int unsigned DWL   = 32;
  localparam int unsigned LANES = 16;
  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = DWL * LANES;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] mult_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] credits;
  logic          overflow;

  mult_result_collector #(
    .dataWidth(DWL), .pactivation(LANES), .LATENCY(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .mult_result(mult_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .credits(credits), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int unsigned due; bit last; } pend_t;
  typedef struct { logic [DW-1:0] data; bit last; int tag; } ent_t;

  pend_t pend[$];
  ent_t  fifo[$];

  int          errors = 0;
  int          checks = 0;
  int unsigned edge_n = 0;
  int          dut_issues = 0;
  bit          tag_mode = 1'b0;
  int          tag_next = 0;
  int          exp_tag = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned mcred();
    return DEPTH - pend.size() - fifo.size();
  endfunction

  function automatic bit exp_last(input logic l);
`ifdef COLLECT_LAST_EN
    return l;
`else
    return 1'b0 & l;
`endif
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(LANES); i++) v[DWL*i +: DWL] = $urandom();
    return v;
  endfunction

  task automatic check_outputs();
    chk("credits", DW'(credits), DW'(mcred()));
    chk("in_ready", DW'(in_ready), DW'(mcred() != 0));
    chk("out_valid", DW'(out_valid), DW'(fifo.size() != 0));
    chk("overflow", DW'(overflow), DW'(0));
    chk("out_last", DW'(out_last), DW'((fifo.size() != 0) ? fifo[0].last : 1'b0));
    if (fifo.size() != 0) chk("out_data", out_data, fifo[0].data);
  endtask

  // One clock: decide issue/pop from model state, advance model at the edge, then check
  task automatic step();
    bit    iss, pp;
    int    this_tag;
    ent_t  e;
    pend_t p;
    iss      = in_valid && (mcred() != 0);
    pp       = out_ready && (fifo.size() != 0);
    this_tag = -1;
    if (tag_mode && pend.size() != 0 && pend[0].due == edge_n + 1) begin
      mult_result[DWL-1:0] = 32'(tag_next);
      this_tag = tag_next;
      tag_next++;
    end
    if (in_valid && in_ready) dut_issues++;
    if (pp && fifo[0].tag >= 0) begin
      chk("wrap_order", DW'(out_data[DWL-1:0]), DW'(32'(exp_tag)));
      exp_tag++;
    end
    @(posedge clk);
    edge_n++;
    if (pp) void'(fifo.pop_front());
    if (pend.size() != 0 && pend[0].due == edge_n) begin
      e.data = mult_result;
      e.last = pend[0].last;
      e.tag  = this_tag;
      fifo.push_back(e);
      void'(pend.pop_front());
    end
    if (iss) begin
      p.due  = edge_n + LAT;
      p.last = exp_last(in_last);
      pend.push_back(p);
    end
    #1;
    check_outputs();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_credits"}, DW'(credits), DW'(DEPTH));
    chk({tag, "_in_ready"}, DW'(in_ready), DW'(1));
    chk({tag, "_out_valid"}, DW'(out_valid), DW'(0));
    chk({tag, "_out_last"}, DW'(out_last), DW'(0));
    chk({tag, "_overflow"}, DW'(overflow), DW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] one_vec;
    for (int i = 0; i < int'(LANES); i++) one_vec[DWL*i +: DWL] = 32'h3F80_0000;

    // Reset held with in_valid asserted
    rst = 1'b0; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b0; mult_result = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    in_valid = 1'b0;
    rst = 1'b1;

    // Single issue, LATENCY+1 to output, credit held until pop
    mult_result = one_vec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    chk("lat_not_early", DW'(out_valid), DW'(0));
    step();
    chk("lat_valid", DW'(out_valid), DW'(1));
    chk("lat_data", out_data, one_vec);
    chk("lat_credits", DW'(credits), DW'(DEPTH - 1));
    repeat (3) step();
    chk("hold_data", out_data, one_vec);
    out_ready = 1'b1;
    step();
    chk("pop_credits", DW'(credits), DW'(DEPTH));
    chk("pop_empty", DW'(out_valid), DW'(0));

    // Fill with no consumer
    out_ready = 1'b0; in_valid = 1'b1; dut_issues = 0;
    repeat (20) begin mult_result = rand_vec(); step(); end
    chk("fill_issues", DW'(dut_issues), DW'(DEPTH));
    chk("fill_in_ready", DW'(in_ready), DW'(0));
    repeat (LAT + 2) begin mult_result = rand_vec(); step(); end
    chk("full_valid", DW'(out_valid), DW'(1));
    chk("full_credits", DW'(credits), DW'(0));
    chk("full_overflow", DW'(overflow), DW'(0));

    // Stream from full; tagged captures must pop in order across pointer wrap
    tag_mode = 1'b1; tag_next = 0; exp_tag = 0; out_ready = 1'b1;
    repeat (70) begin mult_result = rand_vec(); step(); end
    tag_mode = 1'b0;
    chk("tags_seen", DW'(exp_tag >= 40), DW'(1));

    // Drain, then 3 stored + 5 in flight, then reset
    in_valid = 1'b0;
    repeat (LAT + DEPTH + 4) step();
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin mult_result = rand_vec(); step(); end
    in_valid = 1'b0;
    repeat (LAT + 1) step();
    in_valid = 1'b1;
    repeat (5) begin mult_result = rand_vec(); step(); end
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    pend.delete();
    fifo.delete();
    chk_reset_vals("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (LAT + 4) begin mult_result = rand_vec(); step(); end

    // Group of four with last on the fourth
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_last = (i == 3); mult_result = rand_vec();
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (LAT + 1) step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef COLLECT_LAST_EN
      chk("last_beat", DW'(out_last), DW'(i == 3));
`else
      chk("last_beat", DW'(out_last), DW'(0));
`endif
      step();
    end

    // Random traffic
    repeat (300) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_last     = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      mult_result = rand_vec();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + DEPTH + 2) step();
    chk("final_credits", DW'(credits), DW'(DEPTH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
